// File: rtl/pin_in_debounce.sv
// Synchronises, debounces and edge-detects the raw PIN_IN header bits, with saturating rise counters.
// Define PIN_IN_DEBOUNCE_BYPASS_EN to replace the tick-based filter with a single register stage.
module pin_in_debounce #(
    parameter int unsigned N_IN         = 2,
    parameter int unsigned CLK_DIV      = 33,
    parameter int unsigned STABLE_TICKS = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [N_IN-1:0]         PIN_IN,
    input  logic                    CLEAR,
    output logic                    TICK,
    output logic [N_IN-1:0]         LEVEL,
    output logic [N_IN-1:0]         RISE,
    output logic [N_IN-1:0]         FALL,
    output logic [N_IN*CNT_W-1:0]   RISE_COUNT
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [N_IN-1:0]  r_sync1;
    logic [N_IN-1:0]  r_sync2;
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic [N_IN-1:0]  r_level;
    logic [N_IN-1:0]  r_rise;
    logic [N_IN-1:0]  r_fall;
    logic [CNT_W-1:0] r_cnt [N_IN];

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= PIN_IN;
            r_sync2 <= r_sync1;
        end
    end

    // TICK is registered off the terminal count, so it lands one cycle after r_div == CLK_DIV-1
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == DIV_LAST);
            r_div  <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
        end
    end

`ifdef PIN_IN_DEBOUNCE_BYPASS_EN
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_level <= r_sync2;
            r_rise  <= r_sync2 & ~r_level;
            r_fall  <= ~r_sync2 & r_level;
        end
    end
`else
    localparam int unsigned STAB_W = $clog2(STABLE_TICKS + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);

    logic [STAB_W-1:0] r_stab [N_IN];

    // Hitting STAB_LAST means this tick would bring the count to STABLE_TICKS: accept the new level
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < N_IN; i++) r_stab[i] <= '0;
            r_level <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            if (r_tick) begin
                for (int unsigned i = 0; i < N_IN; i++) begin
                    if (r_sync2[i] != r_level[i]) begin
                        if (r_stab[i] == STAB_LAST) begin
                            r_stab[i]  <= '0;
                            r_level[i] <= ~r_level[i];
                            r_rise[i]  <= ~r_level[i];
                            r_fall[i]  <= r_level[i];
                        end else begin
                            r_stab[i] <= r_stab[i] + STAB_W'(1);
                        end
                    end else begin
                        r_stab[i] <= '0;
                    end
                end
            end
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N || CLEAR) begin
            for (int unsigned i = 0; i < N_IN; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (r_rise[i] && (r_cnt[i] != CNT_MAX)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        RISE_COUNT = '0;
        for (int unsigned i = 0; i < N_IN; i++) RISE_COUNT[i*CNT_W +: CNT_W] = r_cnt[i];
    end

    assign TICK  = r_tick;
    assign LEVEL = r_level;
    assign RISE  = r_rise;
    assign FALL  = r_fall;

endmodule

// File: doc/pin_in_debounce.md
Name: pin_in_debounce

Overview:
Input-conditioning stage directly upstream of the board top level's control logic. It takes the raw asynchronous PIN_IN header bits, synchronises them to CLOCK_50 and debounces them on a prescaled sample tick. It emits clean levels, single-cycle edge pulses and saturating per-channel rising-edge counts for the control logic and LED status. The sample tick is also exported for use as the 1.5 MHz debug strobe.

Parameters:
N_IN, 2, number of input channels
CLK_DIV, 33, CLOCK_50 cycles per sample tick (50 MHz / 33 ≈ 1.5 MHz); legal range ≥ 2
STABLE_TICKS, 16, consecutive ticks of a differing input needed to accept a new level; legal range ≥ 1
CNT_W, 8, width of each rising-edge counter

Ports:
CLOCK_50  in  1  system clock, single clock domain
RESET_N  in  1  synchronous, active-low reset
PIN_IN  in  N_IN  raw asynchronous inputs
CLEAR  in  1  synchronous clear of all edge counters
TICK  out  1  one-cycle sample strobe
LEVEL  out  N_IN  debounced level per channel
RISE  out  N_IN  one-cycle pulse on accepted 0->1
FALL  out  N_IN  one-cycle pulse on accepted 1->0
RISE_COUNT  out  N_IN*CNT_W  per-channel saturating rise counts; channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (RESET_N low at a CLOCK_50 edge) zeroes all state: sync flops, prescaler, stability counters, TICK, LEVEL, RISE, FALL, RISE_COUNT. Reset has priority over everything. Reset mid-debounce discards the pending count.
- Synchroniser: 2 flops per bit, no combinational path from PIN_IN to any output.
- Prescaler: counts 0..CLK_DIV-1, then wraps to 0.
  - TICK is registered and high for exactly one cycle, in the cycle after the prescaler holds CLK_DIV-1.
  - After reset release the first TICK appears CLK_DIV cycles later; thereafter TICK has period CLK_DIV.
- Per-channel filter, evaluated only in cycles where TICK is high:
  - sync bit != LEVEL: stab_cnt increments. When it reaches STABLE_TICKS, LEVEL toggles and stab_cnt returns to 0 in the same edge.
  - sync bit == LEVEL: stab_cnt is cleared to 0.
  - stab_cnt width is clog2(STABLE_TICKS+1).
- RISE/FALL: registered, asserted in the same cycle LEVEL first shows the new value, high for exactly one cycle. RISE and FALL are never both high on one channel.
- Latency: PIN_IN change to LEVEL change is 2 sync cycles, plus wait to the next TICK, plus (STABLE_TICKS-1)*CLK_DIV cycles, plus 1 cycle.
- RISE_COUNT:
  - Increments by 1 in the cycle after RISE is high.
  - Saturates at 2^CNT_W-1 with no wrap.
  - CLEAR zeroes all counts next edge; CLEAR wins over a simultaneous increment.
- LEVEL resets to 0. An input held high through reset produces a RISE once debounced.

Optional Feature:
PIN_IN_DEBOUNCE_BYPASS_EN
- Defined: the filter is removed. LEVEL is the synchroniser output registered once (3-cycle latency, no TICK dependence), and RISE/FALL/RISE_COUNT derive from that LEVEL. The prescaler and TICK are unchanged.
- Undefined: full debounce as specified above.

Test Plan:
- Release RESET_N, PIN_IN=0 -> first TICK 33 cycles after release, then every 33 cycles; LEVEL=0, RISE=FALL=0, RISE_COUNT=0.
- PIN_IN[0] 0->1, held -> LEVEL[0]=1 after 16 ticks (≈530 cycles); RISE[0] high exactly 1 cycle; RISE_COUNT ch0=1, ch1=0. Then 1->0 held -> FALL[0] 1-cycle pulse; count unchanged.
- PIN_IN[1] high for 10 ticks, then low -> LEVEL[1] stays 0, no RISE, count 0. Then high for 16 ticks -> accepted, count ch1=1.
- CNT_W=2, 5 debounced pulses on ch0 -> RISE_COUNT ch0=3 (saturated). Assert CLEAR in the same cycle as the 6th increment -> count 0; next rise -> 1.
- RESET_N low after 8 stable ticks of a pending PIN_IN[0]=1 -> all outputs 0 next edge. After release with input still high -> RISE after a full 16 fresh ticks.
- With PIN_IN_DEBOUNCE_BYPASS_EN defined: PIN_IN[0] toggles for 1 cycle -> LEVEL[0] follows 3 cycles later; RISE and FALL each pulse once; count=1.
